// File: rtl/mcu_mem_pkg.sv
// Shared definitions for the cache's MCU-clock memory port: FSM encoding,
// cache-side read schedule constant and the latched request record.
package mcu_mem_pkg;

  localparam int CACHE_ACK_TO_DATA = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT  = 2'd1,
    ST_RD1  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mcu_rdata_delay.sv
// Re-times SRAM read data so each beat lands CACHE_ACK_TO_DATA cycles after
// its read strobe, whatever the SRAM latency. Data is zero when no beat is valid.
module mcu_rdata_delay
  import mcu_mem_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        re_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  localparam int STAGES = CACHE_ACK_TO_DATA;
  localparam int DLY    = (RD_LAT >= 1 && RD_LAT <= STAGES) ? STAGES - RD_LAT : 0;

  // vld_pipe[k] is high in the k-th cycle after a read strobe.
  logic [STAGES:1] vld_pipe;
  logic [31:0]     dat_dly;

  always_ff @(posedge clk_i) begin
    if (rst_i) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], re_i};
  end

  if (DLY == 0) begin : g_pass
    assign dat_dly = rdata_i;
  end else begin : g_dly
    logic [DLY:1][31:0] dat_pipe;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dat_pipe <= '0;
      end else begin
        dat_pipe[1] <= vld_pipe[RD_LAT] ? rdata_i : 32'h0;
        for (int k = 2; k <= DLY; k++) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
    assign dat_dly = dat_pipe[DLY];
  end

  assign data_o = vld_pipe[STAGES] ? dat_dly : 32'h0;

endmodule

// File: rtl/mcu_sram_port.sv
// Memory-side responder for the cache's MCU-clock request port: one SRAM write
// or a two-beat (A, A^1) read per request, read data on the cache's fixed schedule.
module mcu_sram_port
  import mcu_mem_pkg::*;
#(
  parameter int AW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          MCU_CLK,
  input  logic          RST_SYS,
  input  logic [31:0]   mem_addr,
  input  logic          mem_we,
  input  logic [3:0]    mem_we_array,
  input  logic          mem_do_act,
  input  logic [31:0]   mem_dataintomem,
  output logic          mem_ack,
  output logic [31:0]   mem_datafrommem,
  output logic          ram_req,
  input  logic          ram_gnt,
  output logic          ram_lock,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic          ram_re,
  output logic [3:0]    ram_be,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  if (RD_LAT < 1 || RD_LAT > CACHE_ACK_TO_DATA) begin : g_bad_lat
    $error("mcu_sram_port: RD_LAT must be in 1..4");
  end

  state_e   state_q, state_d;
  mem_req_t req_q, req_d;
  logic     armed_q, armed_d;
  logic     unused_addr;

  assign unused_addr = ^req_q.addr[31:AW];

  always_ff @(posedge MCU_CLK) begin
    if (RST_SYS) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      armed_q <= armed_d;
    end
  end

  // Outputs depend on latched state and grant only; mem_do_act steers next state.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    mem_ack   = 1'b0;
    ram_req   = 1'b0;
    ram_lock  = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = 4'h0;
    ram_wdata = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (mem_do_act && armed_q) begin
          req_d   = '{addr: mem_addr, we: mem_we, be: mem_we_array, wdata: mem_dataintomem};
          state_d = ST_GNT;
        end
      end
      ST_GNT: begin
        ram_req = 1'b1;
        if (ram_gnt) begin
          mem_ack  = 1'b1;
          ram_addr = req_q.addr[AW-1:0];
          if (req_q.we) begin
            ram_we    = 1'b1;
            ram_be    = req_q.be;
            ram_wdata = req_q.wdata;
            state_d   = ST_IDLE;
          end else begin
            ram_re   = 1'b1;
            ram_lock = 1'b1;
            state_d  = ST_RD1;
          end
        end
      end
      ST_RD1: begin
        // Partner word of the aligned pair, matching the cache's fill order.
        ram_re   = 1'b1;
        ram_lock = 1'b1;
        ram_addr = req_q.addr[AW-1:0] ^ AW'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The cache holds its request one cycle past ack; re-arm only after it drops.
  always_comb begin
    armed_d = armed_q;
    if (mem_ack)          armed_d = 1'b0;
    else if (!mem_do_act) armed_d = 1'b1;
  end

  mcu_rdata_delay #(.RD_LAT(RD_LAT)) u_rdata_delay (
    .clk_i   (MCU_CLK),
    .rst_i   (RST_SYS),
    .re_i    (ram_re),
    .rdata_i (ram_rdata),
    .data_o  (mem_datafrommem)
  );

endmodule

// File: tb/tb_mcu_sram_port.sv
// Directed bench: four ports with RD_LAT 1..4 share one stimulus stream, each
// with its own SRAM model of matching latency.
module tb_mcu_sram_port;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] mem_addr, mem_dataintomem;
  logic        mem_we, mem_do_act, ram_gnt;
  logic [3:0]  mem_we_array;

  logic        ack [4];
  logic        req [4];
  logic        lock[4];
  logic        we  [4];
  logic        re  [4];
  logic [15:0] raddr[4];
  logic [3:0]  rbe [4];
  logic [31:0] wdat[4];
  logic [31:0] dfm [4];
  logic [31:0] rdat[4];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    case (a)
      16'h0041: return 32'h1111_1111;
      16'h0040: return 32'h2222_2222;
      default:  return {16'h5A00, a};
    endcase
  endfunction

  function automatic logic [4:0] ctl(input int i);
    return {ack[i], req[i], we[i], re[i], lock[i]};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = g + 1;
    logic [L:1]  mv = '0;
    logic [15:0] ma [L:1];
    always @(posedge clk) begin
      mv[1] <= re[g];
      ma[1] <= raddr[g];
      for (int k = 2; k <= L; k++) begin
        mv[k] <= mv[k-1];
        ma[k] <= ma[k-1];
      end
    end
    // Junk on the bus outside valid beats so ungated data shows up.
    assign rdat[g] = mv[L] ? ram_word(ma[L]) : (32'hEE00_0000 | 32'(g));

    mcu_sram_port #(.AW(16), .RD_LAT(L)) u_dut (
      .MCU_CLK(clk), .RST_SYS(rst),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_we_array(mem_we_array),
      .mem_do_act(mem_do_act), .mem_dataintomem(mem_dataintomem),
      .mem_ack(ack[g]), .mem_datafrommem(dfm[g]),
      .ram_req(req[g]), .ram_gnt(ram_gnt), .ram_lock(lock[g]),
      .ram_addr(raddr[g]), .ram_we(we[g]), .ram_re(re[g]),
      .ram_be(rbe[g]), .ram_wdata(wdat[g]), .ram_rdata(rdat[g])
    );
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic idle_in();
    mem_do_act = 1'b0; mem_we = 1'b0; mem_addr = 32'h0;
    mem_we_array = 4'h0; mem_dataintomem = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_in(); ram_gnt = 1'b0;
    cyc(); cyc(); smp();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({ctl(i), raddr[i], rbe[i], wdat[i], dfm[i]} !== 89'h0) begin
        n_fail++;
        $display("FAIL reset_outputs lat%0d: got ctl=%b addr=%h be=%h wd=%h rd=%h, want all 0",
                 i+1, ctl(i), raddr[i], rbe[i], wdat[i], dfm[i]);
      end
    end
    cyc(); rst = 1'b0;
    smp();
    n_chk++;
    if (ctl(0) !== 5'b00000) begin
      n_fail++; $display("FAIL reset_release: got ctl=%b, want 00000", ctl(0));
    end
    cyc();
  endtask

  task automatic test_write();
    int cnt = 0;
    ram_gnt = 1'b1; mem_do_act = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_1234;
    mem_we_array = 4'hF; mem_dataintomem = 32'hDEAD_BEEF;
    smp();
    n_chk++;
    if (ctl(0) !== 5'b00000) begin
      n_fail++; $display("FAIL wr_accept_cycle: got ctl=%b, want 00000", ctl(0));
    end
    cyc(); smp();
    n_chk++;
    if ({ctl(0), raddr[0], rbe[0], wdat[0]} !== {5'b11100, 16'h1234, 4'hF, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL wr_access: got ctl=%b addr=%h be=%h wd=%h, want 11100 1234 f deadbeef",
               ctl(0), raddr[0], rbe[0], wdat[0]);
    end
    cyc(); idle_in();
    for (int k = 0; k < 4; k++) begin
      smp();
      if (ack[0] || we[0] || re[0]) cnt++;
      cyc();
    end
    n_chk++;
    if (cnt != 0) begin
      n_fail++; $display("FAIL wr_single_access: got %0d extra strobes, want 0", cnt);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] e0, input logic [31:0] e1);
    logic [31:0] exp;
    ram_gnt = 1'b1; mem_do_act = 1'b1; mem_we = 1'b0;
    mem_addr = {16'h0, a}; mem_we_array = 4'h0; mem_dataintomem = 32'h0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 2) idle_in();
      smp();
      if (k == 0) begin
        n_chk++;
        if ({ctl(0), raddr[0], rbe[0]} !== {5'b11011, a, 4'h0}) begin
          n_fail++; $display("FAIL rd_beat0_issue: got ctl=%b addr=%h be=%h, want 11011 %h 0",
                             ctl(0), raddr[0], rbe[0], a);
        end
      end
      if (k == 1) begin
        n_chk++;
        if ({ctl(0), raddr[0]} !== {5'b00011, a ^ 16'h0001}) begin
          n_fail++; $display("FAIL rd_beat1_issue: got ctl=%b addr=%h, want 00011 %h",
                             ctl(0), raddr[0], a ^ 16'h0001);
        end
      end
      for (int i = 0; i < 4; i++) begin
        exp = (k == 4) ? e0 : (k == 5) ? e1 : 32'h0;
        n_chk++;
        if (dfm[i] !== exp) begin
          n_fail++; $display("FAIL rd_data lat%0d I+%0d addr %h: got %h, want %h",
                             i+1, k, a, dfm[i], exp);
        end
      end
    end
    cyc();
  endtask

  task automatic test_read();
    do_read(16'h0041, 32'h1111_1111, 32'h2222_2222);
    do_read(16'h00A6, 32'h5A00_00A6, 32'h5A00_00A7);
    do_read(16'h00FF, 32'h5A00_00FF, 32'h5A00_00FE);
  endtask

  task automatic test_grant_stall();
    ram_gnt = 1'b0; mem_do_act = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0100;
    mem_we_array = 4'h3; mem_dataintomem = 32'h0BAD_F00D;
    for (int k = 0; k < 7; k++) begin
      cyc(); smp();
      n_chk++;
      if ({ctl(0), wdat[0]} !== {5'b01000, 32'h0}) begin
        n_fail++; $display("FAIL stall_cycle%0d: got ctl=%b wd=%h, want 01000 0", k, ctl(0), wdat[0]);
      end
    end
    cyc(); ram_gnt = 1'b1;
    smp();
    n_chk++;
    if ({ctl(0), raddr[0], rbe[0], wdat[0]} !== {5'b11100, 16'h0100, 4'h3, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL stall_release: got ctl=%b addr=%h be=%h wd=%h, want 11100 0100 3 0badf00d",
                         ctl(0), raddr[0], rbe[0], wdat[0]);
    end
    cyc(); idle_in();
    smp();
    n_chk++;
    if (ctl(0) !== 5'b00000) begin
      n_fail++; $display("FAIL stall_after: got ctl=%b, want 00000", ctl(0));
    end
    cyc();
  endtask

  task automatic test_ack_tail();
    int nacc = 0;
    ram_gnt = 1'b1; mem_do_act = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0200;
    mem_we_array = 4'hF; mem_dataintomem = 32'h1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) mem_do_act = 1'b0;
      if (k == 4) begin mem_do_act = 1'b1; mem_addr = 32'h0000_0201; mem_dataintomem = 32'h2; end
      if (k == 6) idle_in();
      smp();
      if (we[0]) nacc++;
      if (k >= 2 && k <= 4) begin
        n_chk++;
        if (ctl(0) !== 5'b00000) begin
          n_fail++; $display("FAIL tail_cycle%0d: got ctl=%b, want 00000", k, ctl(0));
        end
      end
      if (k == 5) begin
        n_chk++;
        if ({ctl(0), raddr[0], wdat[0]} !== {5'b11100, 16'h0201, 32'h2}) begin
          n_fail++; $display("FAIL tail_second_access: got ctl=%b addr=%h wd=%h, want 11100 0201 2",
                             ctl(0), raddr[0], wdat[0]);
        end
      end
      cyc();
    end
    n_chk++;
    if (nacc != 2) begin
      n_fail++; $display("FAIL tail_access_count: got %0d, want 2", nacc);
    end
  endtask

  task automatic test_reset_mid_read();
    ram_gnt = 1'b1; mem_do_act = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0080;
    cyc(); smp();
    n_chk++;
    if (ctl(0) !== 5'b11011) begin
      n_fail++; $display("FAIL rst_mid_issue: got ctl=%b, want 11011", ctl(0));
    end
    cyc();
    cyc(); idle_in(); rst = 1'b1;
    cyc(); rst = 1'b0;
    smp();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({ctl(i), raddr[i], rbe[i], wdat[i], dfm[i]} !== 89'h0) begin
        n_fail++; $display("FAIL rst_mid_outputs lat%0d: got ctl=%b addr=%h rd=%h, want all 0",
                           i+1, ctl(i), raddr[i], dfm[i]);
      end
    end
    for (int k = 4; k < 8; k++) begin
      cyc(); smp();
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (dfm[i] !== 32'h0) begin
          n_fail++; $display("FAIL rst_mid_discard lat%0d I+%0d: got %h, want 0", i+1, k, dfm[i]);
        end
      end
    end
    cyc();
    do_read(16'h0041, 32'h1111_1111, 32'h2222_2222);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    ram_gnt = 1'b1; mem_do_act = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0041;
    mem_we_array = 4'h0; mem_dataintomem = 32'h0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (k == 2) mem_do_act = 1'b0;
      if (k == 3) begin
        mem_do_act = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0300;
        mem_we_array = 4'h5; mem_dataintomem = 32'hCAFE_F00D;
      end
      if (k == 5) idle_in();
      smp();
      if (k == 3 || k == 5) begin
        n_chk++;
        if (ctl(0) !== 5'b00000) begin
          n_fail++; $display("FAIL b2b_quiet I+%0d: got ctl=%b, want 00000", k, ctl(0));
        end
      end
      if (k == 4) begin
        n_chk++;
        if ({ctl(0), raddr[0], rbe[0], wdat[0]} !== {5'b11100, 16'h0300, 4'h5, 32'hCAFE_F00D}) begin
          n_fail++; $display("FAIL b2b_write: got ctl=%b addr=%h be=%h wd=%h, want 11100 0300 5 cafef00d",
                             ctl(0), raddr[0], rbe[0], wdat[0]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        exp = (k == 4) ? 32'h1111_1111 : (k == 5) ? 32'h2222_2222 : 32'h0;
        n_chk++;
        if (dfm[i] !== exp) begin
          n_fail++; $display("FAIL b2b_data lat%0d I+%0d: got %h, want %h", i+1, k, dfm[i], exp);
        end
      end
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_grant_stall();
    test_ack_tail();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
